branch_predict_resolve: RTL



---
 rtl/branch_pkg.sv | 37 +++
 rtl/branch_predict_resolve_bht_table.sv | 54 +++++
 rtl/branch_predict_resolve.sv | 139 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared BrOp field constants, BHT counter type/encodings and
//               the conditional-branch classifier used by the branch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // BrOp[4] marks an unconditional jump; BrOp[4:3] == BR_COND_TAG marks a
    // conditional branch whose compare is selected by BrOp[2:0].
    localparam int         BR_JUMP_BIT = 4;
    localparam logic [1:0] BR_COND_TAG = 2'b01;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t CTR_SNT   = 2'b00;
    localparam bht_ctr_t CTR_WNT   = 2'b01;
    localparam bht_ctr_t CTR_WT    = 2'b10;
    localparam bht_ctr_t CTR_ST    = 2'b11;
    localparam bht_ctr_t CTR_RESET = CTR_WNT;

    // Compare codes 010/011 inside the conditional group are holes: they are
    // never taken and must not train the BHT or bump the counters.
    function automatic logic is_cond_branch(input logic [4:0] br_op);
        return (br_op[4:3] == BR_COND_TAG) && (br_op[2:1] != 2'b01);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_resolve_bht_table.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_resolve_bht_table (bht_table)
// Description : Direct-mapped array of 2-bit saturating counters.
//               One combinational read port, one saturating update port.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_rd_idx/o_rd_ctr - read index / counter value (no bypass)
//               i_wr_en/i_wr_idx  - train enable / index
//               i_wr_taken        - 1: increment, 0: decrement (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module bht_table
    import branch_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output bht_ctr_t         o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    bht_ctr_t r_ctr [ENTRIES];
    bht_ctr_t w_cur;
    bht_ctr_t w_nxt;

    // Read returns the stored value; a same-cycle update becomes visible
    // only after the edge.
    assign o_rd_ctr = r_ctr[i_rd_idx];
    assign w_cur    = r_ctr[i_wr_idx];

    always_comb begin
        w_nxt = w_cur;
        if (i_wr_taken) begin
            if (w_cur != CTR_ST) w_nxt = w_cur + 2'd1;
        end else begin
            if (w_cur != CTR_SNT) w_nxt = w_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_RESET;
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= w_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_resolve
// Description : EX-stage branch resolution with a 2-bit BHT predictor,
//               misprediction flag and wrap-around performance counters.
// Ports       : clk, rst_n              - clock, async active-low reset
//               if_pc -> if_pred_taken   - fetch-side BHT lookup
//               ex_valid, ex_pc, In1, In2, BrOp, ex_pred_taken - EX inputs
//               NextPCSrc, mispredict    - combinational resolve results
//               stats_clr, br_count, mp_count - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  In1,
    input  logic [XLEN-1:0]  In2,
    input  logic [4:0]       BrOp,
    input  logic             ex_pred_taken,
    output logic             NextPCSrc,
    output logic             mispredict,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int c_IDX_W = $clog2(BHT_ENTRIES);

    logic [c_IDX_W-1:0] w_if_idx;
    logic [c_IDX_W-1:0] w_ex_idx;
    bht_ctr_t           w_if_ctr;
    logic               w_is_cond;
    logic               w_is_jump;
    logic               w_cond_taken;
    logic               w_train;
    logic               w_eq;
    logic               w_lt;
    logic               w_ltu;
    logic [CNT_W-1:0]   w_br_count_nxt;
    logic [CNT_W-1:0]   w_mp_count_nxt;
    logic [CNT_W-1:0]   r_br_count;
    logic [CNT_W-1:0]   r_mp_count;
    logic               w_unused_pc_bits;

    // Word-aligned PCs: drop the byte offset, keep IDX_W index bits.
    assign w_if_idx = if_pc[c_IDX_W+1:2];
    assign w_ex_idx = ex_pc[c_IDX_W+1:2];
    assign w_unused_pc_bits = ^{if_pc, ex_pc};

    assign w_is_jump = BrOp[BR_JUMP_BIT];
    assign w_is_cond = is_cond_branch(BrOp);

    assign w_eq  = (In1 == In2);
    assign w_lt  = ($signed(In1) < $signed(In2));
    assign w_ltu = (In1 < In2);

    always_comb begin
        w_cond_taken = 1'b0;
        case (BrOp[2:0])
            BR_EQ:   w_cond_taken = w_eq;
            BR_NE:   w_cond_taken = ~w_eq;
            BR_LT:   w_cond_taken = w_lt;
            BR_GE:   w_cond_taken = ~w_lt;
            BR_LTU:  w_cond_taken = w_ltu;
            BR_GEU:  w_cond_taken = ~w_ltu;
            default: w_cond_taken = 1'b0;
        endcase
    end

    always_comb begin
        NextPCSrc  = 1'b0;
        mispredict = 1'b0;
        if (w_is_jump) begin
            NextPCSrc  = 1'b1;
            mispredict = ex_valid & ~ex_pred_taken;
        end else if (w_is_cond) begin
            NextPCSrc  = w_cond_taken;
            mispredict = ex_valid & (w_cond_taken != ex_pred_taken);
        end
    end

    // Only valid conditional branches train and count; jumps never do.
    assign w_train = ex_valid & w_is_cond;

    bht_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (c_IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (w_if_idx),
        .o_rd_ctr   (w_if_ctr),
        .i_wr_en    (w_train),
        .i_wr_idx   (w_ex_idx),
        .i_wr_taken (w_cond_taken)
    );

    assign if_pred_taken = w_if_ctr[1];

    // Clear wins over a same-cycle increment; both counters wrap naturally.
    always_comb begin
        w_br_count_nxt = r_br_count;
        w_mp_count_nxt = r_mp_count;
        if (stats_clr) begin
            w_br_count_nxt = '0;
            w_mp_count_nxt = '0;
        end else if (w_train) begin
            w_br_count_nxt = r_br_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (mispredict) begin
                w_mp_count_nxt = r_mp_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count <= '0;
            r_mp_count <= '0;
        end else begin
            r_br_count <= w_br_count_nxt;
            r_mp_count <= w_mp_count_nxt;
        end
    end

    assign br_count = r_br_count;
    assign mp_count = r_mp_count;

endmodule
`default_nettype wire
